exp_result_fifo: RTL and testbench

//  Downstream result buffer for the pipelined exponent stage (x^8, 64-bit results).
//  - Captures the stage's o_valid/o_data stream, which has no backpressure.
//  - Re-presents results to a consumer over a ready/valid handshake.
//  - Drives o_afull back to the stimulus source so issue stops while the pipe's
//    in-flight results can still be absorbed.

---
 rtl/exp_result_fifo.sv | 106 ++++++++++
 tb/tb_exp_result_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/exp_result_fifo.sv
// Result buffer behind the pipelined x^8 stage: absorbs a non-stallable result stream and
// re-presents it first-word-fall-through over ready/valid. Optional drop counter: EXP_FIFO_STATS_EN.
module exp_result_fifo #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 8,
  parameter int IN_FLIGHT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_data,
  output logic                     o_afull,
  output logic                     o_ovf,
  input  logic                     i_clr_ovf,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count
`ifdef EXP_FIFO_STATS_EN
  ,output logic [15:0]             o_drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_TH = PW'(DEPTH - IN_FLIGHT);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_count;
  logic              r_ovf;

  logic w_empty;
  logic w_full;
  logic w_rd_fire;
  logic w_wr_en;
  logic w_drop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_rd_fire = !w_empty && i_ready;
  // A read on the same edge frees the slot, so a full buffer can still accept a write.
  assign w_wr_en   = i_valid && (!w_full || w_rd_fire);
  assign w_drop    = i_valid && w_full && !w_rd_fire;

  // Storage is deliberately left out of reset; stale words are masked by the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_wr_en, w_rd_fire})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef EXP_FIFO_STATS_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (i_clr_ovf) begin
        r_drop_cnt <= 16'd1;
      end else if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end else if (i_clr_ovf) begin
      r_drop_cnt <= '0;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_count = r_count;
  assign o_afull = (r_count >= AFULL_TH);
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_exp_result_fifo.sv
// Scoreboard bench for exp_result_fifo: accepted words are queued, reads are popped and compared,
// and a small occupancy/overflow model is checked every cycle on the falling edge.
module tb_exp_result_fifo;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int IN_FL  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_afull;
  logic              o_ovf;
  logic              i_clr_ovf;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;
  logic [3:0]        o_count;
`ifdef EXP_FIFO_STATS_EN
  logic [15:0]       o_drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] sb_q [$];
  logic              exp_ovf = 1'b0;
`ifdef EXP_FIFO_STATS_EN
  logic [15:0]       exp_drop = 16'd0;
`endif

  exp_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IN_FLIGHT(IN_FL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_afull   (o_afull),
    .o_ovf     (o_ovf),
    .i_clr_ovf (i_clr_ovf),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .i_ready   (i_ready),
    .o_count   (o_count)
`ifdef EXP_FIFO_STATS_EN
    ,.o_drop_cnt(o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pow8(input int x);
    logic [63:0] v;
    v = 64'(x);
    return v * v * v * v * v * v * v * v;
  endfunction

  // Drive one cycle of inputs, then move to just after the next rising edge.
  task automatic step(input logic v, input logic [63:0] d, input logic rdy);
    i_valid = v;
    i_data  = d;
    i_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sb_q.size() != 0; k++) begin
      step(1'b0, 64'd0, 1'b1);
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Falling-edge monitor: compares DUT state with the model, then advances the model
  // to what the coming rising edge should do.
  always @(negedge clk) begin
    logic exp_valid, rd, wr, drop;
    if (!rst_n) begin
      sb_q.delete();
      exp_ovf = 1'b0;
`ifdef EXP_FIFO_STATS_EN
      exp_drop = 16'd0;
`endif
    end else begin
      exp_valid = (sb_q.size() != 0);
      check("o_valid", 64'(o_valid), 64'(exp_valid));
      check("o_count", 64'(o_count), 64'(sb_q.size()));
      check("o_afull", 64'(o_afull), 64'(sb_q.size() >= DEPTH - IN_FL));
      check("o_ovf", 64'(o_ovf), 64'(exp_ovf));
`ifdef EXP_FIFO_STATS_EN
      check("o_drop_cnt", 64'(o_drop_cnt), 64'(exp_drop));
`endif
      check("o_data", o_data, exp_valid ? sb_q[0] : 64'd0);
      rd   = exp_valid && i_ready;
      wr   = i_valid && (sb_q.size() < DEPTH || rd);
      drop = i_valid && !wr;
      if (rd) begin
        $display("rd  data=%h count=%0d", sb_q[0], sb_q.size());
        void'(sb_q.pop_front());
      end
      if (wr) sb_q.push_back(i_data);
      if (drop) $display("drop data=%h", i_data);
      if (drop) exp_ovf = 1'b1;
      else if (i_clr_ovf) exp_ovf = 1'b0;
`ifdef EXP_FIFO_STATS_EN
      if (drop) exp_drop = i_clr_ovf ? 16'd1 : (exp_drop == 16'hFFFF ? exp_drop : exp_drop + 16'd1);
      else if (i_clr_ovf) exp_drop = 16'd0;
`endif
    end
  end

  initial begin
    rst_n     = 1'b0;
    i_valid   = 1'b0;
    i_data    = '0;
    i_ready   = 1'b0;
    i_clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_afull", 64'(o_afull), 64'd0);
    check("rst_ovf", 64'(o_ovf), 64'd0);
    check("rst_data", o_data, 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stream of x^8 results with the consumer always ready.
    for (int i = 0; i < 100; i++) begin
      step(1'b1, pow8(i), 1'b1);
      check("stream_cnt_le1", 64'(o_count <= 1), 64'd1);
    end
    drain();

    // Fill to full, then read out in order.
    for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b0);
    step(1'b0, 64'd0, 1'b0);
    check("fill_count", 64'(o_count), 64'd8);
    check("fill_afull", 64'(o_afull), 64'd1);
    drain();
    check("fill_empty_valid", 64'(o_valid), 64'd0);

    // Overflow while full and stalled.
    for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b0);
    step(1'b1, 64'hDEAD, 1'b0);
    check("ovf_set", 64'(o_ovf), 64'd1);
    check("ovf_count", 64'(o_count), 64'd8);
    step(1'b0, 64'd0, 1'b0);
    check("ovf_sticky", 64'(o_ovf), 64'd1);
    i_clr_ovf = 1'b1;
    step(1'b0, 64'd0, 1'b0);
    i_clr_ovf = 1'b0;
    check("ovf_clr", 64'(o_ovf), 64'd0);

    // Simultaneous read and write while full.
    step(1'b1, 64'd9, 1'b1);
    check("full_rw_count", 64'(o_count), 64'd8);
    check("full_rw_ovf", 64'(o_ovf), 64'd0);
    drain();

    // Pointer wrap at steady occupancy 3.
    for (int i = 0; i < 3; i++) step(1'b1, 64'(100 + i), 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 64'(200 + k), 1'b1);
      check("wrap_count", 64'(o_count), 64'd3);
    end
    drain();

    // Asynchronous reset mid-run.
    for (int i = 1; i <= 5; i++) step(1'b1, 64'(50 + i), 1'b0);
    i_valid = 1'b0;
    check("pre_rst_count", 64'(o_count), 64'd5);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(o_valid), 64'd0);
    check("arst_count", 64'(o_count), 64'd0);
    check("arst_afull", 64'(o_afull), 64'd0);
    check("arst_ovf", 64'(o_ovf), 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 64'd7, 1'b0);
    check("post_rst_data", o_data, 64'd7);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
